// File: rtl/rv_regfile_sb.sv
// Integer register file with NRD combinational read ports, write-first bypass
// and a pending-write scoreboard used by decode for RAW stall detection.
module rv_regfile_sb #(
  parameter int                DWIDTH  = 32,
  parameter int                NREGS   = 32,
  parameter int                NRD     = 2,
  parameter logic [DWIDTH-1:0] SP_INIT = DWIDTH'(32'h0110_0000)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NRD*$clog2(NREGS)-1:0]   rs_addr,
  output logic [NRD*DWIDTH-1:0]          rs_data,
  output logic [NRD-1:0]                 rs_busy,
  input  logic                           wren,
  input  logic [$clog2(NREGS)-1:0]       rd_addr,
  input  logic [DWIDTH-1:0]              rd_data,
  input  logic                           issue_valid,
  input  logic [$clog2(NREGS)-1:0]       issue_rd,
  output logic [$clog2(NREGS):0]         pending_cnt,
  output logic [NREGS-1:0]               pending_mask
);

  localparam int RW = $clog2(NREGS);

  // Interface contract: there is no handshake. A write is accepted on every
  // rising edge where wren is high and rd_addr != 0; an issue is accepted on
  // every rising edge where issue_valid is high and issue_rd != 0. Decode is
  // expected to hold off issue while rs_busy is set for a source it needs.

  logic [DWIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pend_nxt;
  logic [RW:0]       cnt_nxt;
  logic              wr_en;
  logic              set_en;

  assign wr_en  = wren && (rd_addr != '0);
  assign set_en = issue_valid && (issue_rd != '0);

  // Register storage; index 0 is never written so it stays at its reset zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        if (NREGS > 2 && i == 2) regs[i] <= SP_INIT;
        else                     regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // Set is applied after clear so a same-cycle collision leaves the register
  // pending: the newly issued writer owns it.
  always_comb begin
    pend_nxt = pending;
    if (wr_en)  pend_nxt[rd_addr]  = 1'b0;
    if (set_en) pend_nxt[issue_rd] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + {{RW{1'b0}}, pend_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pend_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  assign pending_mask = pending;

  // Per-port read with same-cycle bypass; bypass is suppressed during reset so
  // the ports show the reset contents while reset is held.
  for (genvar gp = 0; gp < NRD; gp++) begin : g_rd
    logic [RW-1:0] addr;
    logic          hit;

    assign addr = rs_addr[gp*RW +: RW];
    assign hit  = wr_en && !reset && (rd_addr == addr);

    assign rs_data[gp*DWIDTH +: DWIDTH] = hit             ? rd_data :
                                          (addr == '0)    ? '0      :
                                          regs[addr];
    assign rs_busy[gp] = pending[addr] && !hit;
  end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Directed self-checking bench for rv_regfile_sb: default 32x32/2-port
// instance plus a 16-register, 4-port instance.
module tb_rv_regfile_sb;

  localparam logic [31:0] SP = 32'h0110_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance: NREGS=32, NRD=2, RW=5
  logic        reset;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic        wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [5:0]  pending_cnt;
  logic [31:0] pending_mask;

  // wide instance: NREGS=16, NRD=4, RW=4
  logic         reset4;
  logic [15:0]  rs_addr4;
  logic [127:0] rs_data4;
  logic [3:0]   rs_busy4;
  logic         wren4;
  logic [3:0]   rd_addr4;
  logic [31:0]  rd_data4;
  logic         issue_valid4;
  logic [3:0]   issue_rd4;
  logic [4:0]   pending_cnt4;
  logic [15:0]  pending_mask4;

  rv_regfile_sb u_dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data),
    .rs_busy(rs_busy), .wren(wren), .rd_addr(rd_addr), .rd_data(rd_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .pending_cnt(pending_cnt), .pending_mask(pending_mask)
  );

  rv_regfile_sb #(.DWIDTH(32), .NREGS(16), .NRD(4)) u_dut4 (
    .clk(clk), .reset(reset4), .rs_addr(rs_addr4), .rs_data(rs_data4),
    .rs_busy(rs_busy4), .wren(wren4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .issue_valid(issue_valid4), .issue_rd(issue_rd4),
    .pending_cnt(pending_cnt4), .pending_mask(pending_mask4)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    wren = 1'b1; rd_addr = a; rd_data = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic issue1(input logic [4:0] a);
    issue_valid = 1'b1; issue_rd = a;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic write4(input logic [3:0] a, input logic [31:0] d);
    wren4 = 1'b1; rd_addr4 = a; rd_data4 = d;
    tick();
    wren4 = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] a);
    issue_valid4 = 1'b1; issue_rd4 = a;
    tick();
    issue_valid4 = 1'b0;
  endtask

  logic [31:0] wvals [4];
  logic [31:0] popped;

  initial begin
    reset = 1'b1; rs_addr = '0; wren = 1'b0; rd_addr = '0; rd_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    reset4 = 1'b1; rs_addr4 = '0; wren4 = 1'b0; rd_addr4 = '0; rd_data4 = '0;
    issue_valid4 = 1'b0; issue_rd4 = '0;
    wvals[0] = 32'h0BAD_F00D; wvals[1] = 32'hCAFE_0001;
    wvals[2] = 32'h8000_0000; wvals[3] = 32'hFFFF_FFFF;

    // reset values visible while reset is held, before any clock edge
    #2;
    rs_addr = {5'd2, 5'd0};
    #1;
    check("rst_r0", rs_data[31:0], 32'h0);
    check("rst_r2", rs_data[63:32], SP);
    rs_addr = {5'd5, 5'd5};
    wren = 1'b1; rd_addr = 5'd5; rd_data = 32'h1111_1111;
    #1;
    check("rst_r5_nobypass", rs_data[63:32], 32'h0);
    check("rst_busy", rs_busy, 2'b00);
    check("rst_cnt", pending_cnt, 6'd0);
    tick();
    check("rst_r5_after_edge", rs_data[31:0], 32'h0);
    wren = 1'b0;
    reset = 1'b0;

    // write / readback on both ports
    write1(5'd5, 32'hDEAD_BEEF);
    rs_addr = {5'd5, 5'd5};
    #1;
    check("wr5_p0", rs_data[31:0], 32'hDEAD_BEEF);
    check("wr5_p1", rs_data[63:32], 32'hDEAD_BEEF);
    write1(5'd0, 32'h0000_1234);
    rs_addr = {5'd0, 5'd0};
    #1;
    check("wr0_ignored", rs_data[31:0], 32'h0);
    check("wr0_cnt", pending_cnt, 6'd0);

    // queued readback of several registers, including the top index 31
    for (int i = 0; i < 4; i++) begin
      write1(5'(28 + i), wvals[i]);
      exp_q.push_back(wvals[i]);
    end
    for (int i = 0; i < 4; i++) begin
      rs_addr = {5'd0, 5'(28 + i)};
      #1;
      popped = exp_q.pop_front();
      check($sformatf("readback_r%0d", 28 + i), rs_data[31:0], popped);
    end

    // scoreboard set / clear on reg 3
    issue1(5'd3);
    rs_addr = {5'd0, 5'd3};
    #1;
    check("sb_busy3", rs_busy, 2'b01);
    check("sb_cnt1", pending_cnt, 6'd1);
    check("sb_mask3", pending_mask, 32'h0000_0008);
    wren = 1'b1; rd_addr = 5'd3; rd_data = 32'h0000_0033;
    #1;
    check("sb_wb_bypass_busy", rs_busy, 2'b00);
    check("sb_wb_bypass_data", rs_data[31:0], 32'h0000_0033);
    tick();
    wren = 1'b0;
    #1;
    check("sb_clear_busy", rs_busy, 2'b00);
    check("sb_clear_cnt", pending_cnt, 6'd0);
    issue1(5'd0);
    check("sb_issue0_cnt", pending_cnt, 6'd0);
    check("sb_issue0_mask", pending_mask, 32'h0);

    // bypass on port 1 for a pending register
    issue1(5'd7);
    rs_addr = {5'd7, 5'd5};
    #1;
    check("byp_busy_before", rs_busy, 2'b10);
    wren = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5_A5A5;
    #1;
    check("byp_data1", rs_data[63:32], 32'hA5A5_A5A5);
    check("byp_busy1", rs_busy, 2'b00);
    check("byp_p0_untouched", rs_data[31:0], 32'hDEAD_BEEF);
    tick();
    wren = 1'b0;
    #1;
    check("byp_cnt_after", pending_cnt, 6'd0);

    // set/clear collision on reg 4: new data lands, register stays pending
    issue1(5'd4);
    check("coll_cnt_before", pending_cnt, 6'd1);
    wren = 1'b1; rd_addr = 5'd4; rd_data = 32'h0000_0044;
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    wren = 1'b0; issue_valid = 1'b0;
    rs_addr = {5'd0, 5'd4};
    #1;
    check("coll_data", rs_data[31:0], 32'h0000_0044);
    check("coll_busy", rs_busy, 2'b01);
    check("coll_cnt", pending_cnt, 6'd1);
    check("coll_mask", pending_mask, 32'h0000_0010);

    // re-issue of an already pending register does not double count
    issue1(5'd4);
    check("reissue_cnt", pending_cnt, 6'd1);

    // async reset mid-cycle with 3 pending and reg 2 overwritten
    issue1(5'd8);
    issue1(5'd9);
    write1(5'd2, 32'h2222_2222);
    rs_addr = {5'd8, 5'd2};
    #1;
    check("pre_rst_cnt", pending_cnt, 6'd3);
    check("pre_rst_r2", rs_data[31:0], 32'h2222_2222);
    check("pre_rst_busy", rs_busy, 2'b10);
    reset = 1'b1;
    #1;
    check("arst_cnt", pending_cnt, 6'd0);
    check("arst_mask", pending_mask, 32'h0);
    check("arst_r2", rs_data[31:0], SP);
    check("arst_busy", rs_busy, 2'b00);
    rs_addr = {5'd5, 5'd4};
    #1;
    check("arst_r4", rs_data[31:0], 32'h0);
    check("arst_r5", rs_data[63:32], 32'h0);
    reset = 1'b0;

    // wide instance: NREGS=16, NRD=4
    reset4 = 1'b0;
    rs_addr4 = {4'd0, 4'd0, 4'd0, 4'd2};
    #1;
    check("w4_rst_r2", rs_data4[31:0], SP);
    write4(4'd15, 32'hF00D_000F);
    rs_addr4 = {4'd15, 4'd15, 4'd0, 4'd15};
    #1;
    check("w4_r15_p3", rs_data4[127:96], 32'hF00D_000F);
    check("w4_r15_p0", rs_data4[31:0], 32'hF00D_000F);
    check("w4_r0_p1", rs_data4[63:32], 32'h0);
    issue4(4'd3);
    issue4(4'd5);
    issue4(4'd6);
    write4(4'd2, 32'h2222_2222);
    rs_addr4 = {4'd6, 4'd5, 4'd3, 4'd2};
    #1;
    check("w4_busy", rs_busy4, 4'b1110);
    check("w4_cnt", pending_cnt4, 5'd3);
    check("w4_r2", rs_data4[31:0], 32'h2222_2222);
    wren4 = 1'b1; rd_addr4 = 4'd5; rd_data4 = 32'h0000_0555;
    #1;
    check("w4_byp_busy", rs_busy4, 4'b1010);
    check("w4_byp_data", rs_data4[95:64], 32'h0000_0555);
    wren4 = 1'b0;
    #1;
    reset4 = 1'b1;
    #1;
    check("w4_arst_cnt", pending_cnt4, 5'd0);
    check("w4_arst_mask", pending_mask4, 16'h0);
    check("w4_arst_busy", rs_busy4, 4'b0000);
    check("w4_arst_r2", rs_data4[31:0], SP);
    reset4 = 1'b0;
    tick();
    check("w4_post_rst_cnt", pending_cnt4, 5'd0);

    // default instance unaffected by the wide instance's reset
    check("d1_cnt_final", pending_cnt, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_regfile_sb.md
Name: rv_regfile_sb

Overview:
Parametrised integer register file with scoreboard, successor to the single-cycle core's two-read/one-write file. Generalised to NRD read ports and a configurable register count. Adds same-cycle write-to-read bypass and a pending-write scoreboard that the pipelined core's decode stage uses for RAW stall detection. Sits between decode (reads, issue) and writeback (write, pending clear).

Parameters:
DWIDTH, 32, register data width
NREGS, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero
NRD, 2, number of independent read ports (1..4)
SP_INIT, 32'h0110_0000, reset value of register 2 (stack pointer); ignored if NREGS<=2
RW, $clog2(NREGS), register index width (derived, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
rs_addr  in  NRD*RW  packed read indices; port i at bits [i*RW +: RW]
rs_data  out  NRD*DWIDTH  packed read data; port i at bits [i*DWIDTH +: DWIDTH]
rs_busy  out  NRD  port i source has a pending write (RAW hazard)
wren  in  1  writeback write enable
rd_addr  in  RW  writeback destination index
rd_data  in  DWIDTH  writeback data
issue_valid  in  1  decode issued an instruction that will write issue_rd
issue_rd  in  RW  destination of the issued instruction
pending_cnt  out  RW+1  number of registers currently marked pending
pending_mask  out  NREGS  per-register pending bit (debug/probe)

Behaviour:
- Reset (async assert, sync deassert by the driving logic): all registers 0 except reg 2 = SP_INIT; all pending bits 0; pending_cnt 0. While reset is high, rs_data reflects these values and rs_busy = 0.
- Storage: NREGS x DWIDTH flops. Reg 0 is never written, always reads 0.
- Write: on posedge, if wren and rd_addr != 0, reg[rd_addr] <= rd_data. Write with rd_addr = 0 is a no-op.
- Read: combinational, zero latency, all NRD ports independent; identical addresses on several ports are legal.
- Bypass: if wren and rd_addr != 0 and rd_addr == rs_addr[i], rs_data[i] = rd_data in the same cycle (write-first). Otherwise rs_data[i] = reg[rs_addr[i]].
- Scoreboard set: on posedge, if issue_valid and issue_rd != 0, pending[issue_rd] <= 1.
- Scoreboard clear: on posedge, if wren and rd_addr != 0, pending[rd_addr] <= 0.
- Simultaneous set and clear of the same register: set wins, the register stays pending. The newer in-flight writer owns it.
- Set of an already-pending register: stays 1, no counting of multiple writers. Decode stalls on WAW, so this case indicates a caller error and is tolerated silently.
- Clear of a non-pending register: no effect.
- Busy: rs_busy[i] = pending[rs_addr[i]] AND NOT (wren AND rd_addr == rs_addr[i] AND rd_addr != 0). The bypassed value satisfies the hazard in the same cycle. rs_busy for index 0 is always 0.
- pending_cnt: registered popcount of the next-state pending vector; it equals the popcount of pending_mask at all times. Maximum value is NREGS-1, so it cannot overflow.
- Reset mid-operation: asserting reset immediately clears all pending bits and restores register contents regardless of wren or issue_valid.
- No X-propagation: out-of-range cannot occur because NREGS is a power of two.

Test Plan:
- Reset: assert reset, read regs 0, 2 and 5 -> 0, 32'h0110_0000 and 0; rs_busy = 0; pending_cnt = 0.
- Write/readback: write reg 5 = 32'hDEAD_BEEF, next cycle read 5 on all ports -> 32'hDEAD_BEEF. Write reg 0 = 32'h1234 -> reg 0 still reads 0.
- Bypass: in the same cycle wren, rd 7 = 32'hA5A5_A5A5 and rs_addr[1] = 7 -> rs_data[1] = 32'hA5A5_A5A5 with rs_busy[1] = 0 even though 7 is pending.
- Scoreboard: issue rd 3 -> next cycle rs_busy = 1 on a port reading 3 and pending_cnt = 1. Then write 3 -> after the edge busy = 0 and pending_cnt = 0. Issue rd 0 -> pending_cnt stays 0.
- Set/clear collision: reg 4 pending, then in the same cycle wren rd 4 and issue rd 4 -> reg 4 holds the new data, still pending, pending_cnt unchanged.
- Async reset mid-run: with 3 pending registers and reg 2 overwritten, pulse reset between clock edges -> pending_cnt = 0 and reg 2 = SP_INIT immediately, without a clock edge. Repeat with NRD = 4 and NREGS = 16.
